// File: rtl/hazard_ctrl.sv
// Purpose : stall/flush controller for a 5-stage MIPS pipeline with branches and jr resolved in ID.
// Latency : stall/flush outputs are combinational in the detection cycle; state and counters update on the clk edge.
// Backpres: a stall holds PC and IF/ID and bubbles ID/EX; a stall always masks the IF flush.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ID_*                            decode-stage register fields and control class of the IF/ID instruction
//   IDEX_lw/regwrite/dest           producer currently in EX
//   EXMEM_memread/dest              producer currently in MEM
//   PC_write, IFID_write            front-end write enables (0 while stalling)
//   IF_flush                        turns the fetched instruction into a nop (taken transfer)
//   IDEX_bubble                     zeroes control entering ID/EX (1 while stalling)
//   stall_cnt, flush_cnt            saturating event counters
//   busy                            FSM is in HOLD (second cycle of a 2-cycle stall)
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_is_branch,
  input  logic             ID_branch_taken,
  input  logic             ID_is_jump,
  input  logic             ID_is_jr,
  input  logic             IDEX_lw,
  input  logic             IDEX_regwrite,
  input  logic [4:0]       IDEX_dest,
  input  logic             EXMEM_memread,
  input  logic [4:0]       EXMEM_dest,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IF_flush,
  output logic             IDEX_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             busy
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             reads_in_id;   // instruction compares operands in ID
  logic             hz_a, hz_b, hz_c;
  logic [1:0]       need;
  logic             stall, flush;

  // A destination hits the ID instruction if it is nonzero and names rs,
  // or names rt when rt is actually read.
  function automatic logic dest_hit(input logic [4:0] dest, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
    dest_hit = (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
  endfunction

  assign reads_in_id = ID_is_branch | ID_is_jr;

  always_comb begin
    hz_a = IDEX_lw && dest_hit(IDEX_dest, ID_rs, ID_rt, ID_uses_rt);
    hz_b = reads_in_id && IDEX_regwrite && !IDEX_lw &&
           dest_hit(IDEX_dest, ID_rs, ID_rt, ID_uses_rt);
    hz_c = reads_in_id && EXMEM_memread &&
           dest_hit(EXMEM_dest, ID_rs, ID_rt, ID_uses_rt);
    need = 2'd0;
    if (hz_a && reads_in_id)      need = 2'd2;
    else if (hz_a || hz_b || hz_c) need = 2'd1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic. A 2-cycle stall spends its first cycle in RUN and the
  // second in HOLD, so the lw that reaches EX/MEM is never re-detected.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      RUN: begin
        if (need == 2'd2) begin
          state_d = HOLD;
          rem_d   = 2'd1;
        end
      end
      HOLD: begin
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        rem_d   = 2'd0;
      end
    endcase
  end

  // Output logic; reset masks hazards and forces pass behaviour.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!rst) begin
      if (state_q == HOLD) begin
        stall = 1'b1;
      end else if (need != 2'd0) begin
        stall = 1'b1;
      end else begin
        flush = ID_is_jump | ID_is_jr | (ID_is_branch & ID_branch_taken);
      end
    end
  end

  assign PC_write    = ~stall;
  assign IFID_write  = ~stall;
  assign IDEX_bubble = stall;
  assign IF_flush    = flush;
  assign busy        = (state_q == HOLD);

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and flush controller for the five-stage MIPS pipeline with jal/jr support. It drives the write-enable, flush and bubble inputs of the IF/ID and ID/EX pipeline registers, using the destination and control fields those registers present back to it. Branches and jr resolve in ID, so operand dependencies on in-flight results need 1- or 2-cycle stalls; a small FSM sequences those stalls. Taken control transfers raise a one-cycle IF flush. Saturating counters record stall and flush activity for the test bench and debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high
- ID_rs  in  5  rs field of the instruction in IF/ID
- ID_rt  in  5  rt field of the instruction in IF/ID
- ID_uses_rt  in  1  ID instruction reads rt (R-type, beq, bne, sw)
- ID_is_branch  in  1  ID instruction is beq/bne; operands are compared in ID
- ID_branch_taken  in  1  branch condition true; valid only when operands are hazard-free
- ID_is_jump  in  1  ID instruction is j or jal
- ID_is_jr  in  1  ID instruction is jr; it reads rs in ID
- IDEX_lw  in  1  instruction in ID/EX is lw
- IDEX_regwrite  in  1  instruction in ID/EX writes a register
- IDEX_dest  in  5  final destination of the instruction in ID/EX (31 for jal)
- EXMEM_memread  in  1  instruction in EX/MEM is lw
- EXMEM_dest  in  5  destination of the instruction in EX/MEM
- PC_write  out  1  PC update enable
- IFID_write  out  1  IF/ID write enable
- IF_flush  out  1  IF/ID clear (instruction becomes nop)
- IDEX_bubble  out  1  zeroes the control fields entering ID/EX
- stall_cnt  out  CNT_W  count of stall cycles, saturating
- flush_cnt  out  CNT_W  count of flushes, saturating
- busy  out  1  FSM is in HOLD

## Operation
- Matches against register 0 never count as hazards.
- Each bit of hzA, hzB and hzC matches a destination against rs, or against rt when ID_uses_rt=1.
- hzA: IDEX_lw=1 and IDEX_dest matches. This is a load-use hazard.
- hzB: ID_is_branch or ID_is_jr, IDEX_regwrite=1, IDEX_lw=0, and IDEX_dest matches.
- hzC: ID_is_branch or ID_is_jr, EXMEM_memread=1, and EXMEM_dest matches.
- need = 2 if hzA and (ID_is_branch or ID_is_jr).
- need = 1 otherwise if any of hzA, hzB or hzC is set.
- need = 0 otherwise.
- The FSM has two states, RUN and HOLD, plus a 2-bit counter rem.
- RUN, need>0: stall this cycle. If need=2, go to HOLD with rem=1. If need=1, stay in RUN and re-evaluate next cycle.
- RUN, need=0: pass through. If ID_is_jump, ID_is_jr, or (ID_is_branch and ID_branch_taken), assert IF_flush for this cycle.
- HOLD: stall unconditionally; hazard inputs are ignored and no flush is raised. rem decrements; return to RUN after the cycle in which rem=1.
- A stall cycle means PC_write=0, IFID_write=0, IDEX_bubble=1 and IF_flush=0.
- A pass cycle means PC_write=1, IFID_write=1 and IDEX_bubble=0.
- Priority: stall beats flush. A branch never flushes until its operands are clear.
- stall_cnt increments on every stall cycle and holds at 2^CNT_W-1.
- flush_cnt increments on every cycle with IF_flush=1 and holds at 2^CNT_W-1.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, in the same cycle as detection; they take effect at the next clk edge.
- State, rem and both counters update on the rising edge of clk.
- While rst=1: outputs follow pass behaviour with IF_flush=0, all hazard inputs are masked, and counters do not count.
- On the first edge with rst=1: state=RUN, rem=0, stall_cnt=0, flush_cnt=0, busy=0.
- Reset asserted mid-HOLD aborts the stall at the next edge.
- Stall latency per event: load-use costs 1 cycle; a branch or jr on an ALU result costs 1 cycle; a branch or jr on an lw result costs 2 cycles. The lw-in-EX/MEM case of the 2-cycle stall is covered by HOLD, not by re-detection.
- A flush lasts exactly one cycle per taken transfer. A jal flushes once; its link write is unaffected.
- Back-to-back hazards re-evaluate on the cycle after a stall ends, with no idle gap required.
- Counters saturate: at all ones, a further event leaves the value unchanged.

## Test plan
- lw $2 in ID/EX, add $3,$2,$4 in ID (rs=2) -> exactly 1 stall cycle (PC_write=0, IDEX_bubble=1), then pass; stall_cnt=1.
- lw $5 in ID/EX, beq $5,$0 in ID -> 2 stall cycles, busy=1 in the second; then the taken branch asserts IF_flush for 1 cycle; stall_cnt=2, flush_cnt=1.
- add $31 (regwrite) in ID/EX, jr $31 in ID -> 1 stall, then IF_flush=1 for 1 cycle.
- lw $0 in ID/EX, add using rs=0 -> no stall; j in ID -> IF_flush=1, PC_write=1.
- rst asserted during HOLD (with a hazard still driven) -> busy=0, counters=0, and outputs are pass values from the next cycle.
- CNT_W=4 bench with 20 consecutive load-use stalls -> stall_cnt saturates at 15.
